ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single-port 8x4 RAM (clk, data_in, wr, rd, add, data_out).
- Each requester issues one read or write at a time through a req/ack handshake.
- The arbiter serialises requests, drives the RAM control pins for exactly one cycle per access, and returns read data to the requester that issued the read.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arbiter_rr_arb2.sv | 35 +++
 rtl/ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_ram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: FSM encoding, default widths, port ids.
// Pure declarations; no logic, no latency, no flow control.
package ram_arb_pkg;

   localparam int DW_DEF     = 4;
   localparam int AW_DEF     = 3;
   localparam int RD_LAT_DEF = 1;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// 2-way round-robin picker: combinational grant from req and a registered priority pointer.
// Zero latency; the pointer moves only on an update strobe, so a held request is never dropped.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       gnt,
   output logic       vld
);

   // port preferred when both request
   logic prio;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio <= P0;
      end else if (update) begin
         prio <= ~gnt;
      end
   end

   always_comb begin
      vld = |req;
      gnt = P0;
      if (req[0] && req[1]) begin
         gnt = prio;
      end else if (req[1]) begin
         gnt = P1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two req/ack ports onto a single-port RAM; ack 2 cycles (write) or 2+RD_LAT (read) after the sampling edge.
// Requesters hold req until ack; a request arriving mid-transaction waits for the next IDLE cycle.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          busy,
   output logic          ram_wr,
   output logic          ram_rd,
   output logic [AW-1:0] ram_add,
   output logic [DW-1:0] ram_data_in,
   input  logic [DW-1:0] ram_data_out
);

   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   state_t        state_q, state_d;
   logic          gid_q, gid_d;
   logic          we_q, we_d;
   logic [1:0]    cnt_q, cnt_d;

   logic          wr_d, rd_d, ack0_d, ack1_d, busy_d;
   logic [AW-1:0] add_d;
   logic [DW-1:0] din_d, rdata0_d, rdata1_d;

   logic          arb_gnt, arb_vld, arb_upd;

   rr_arb2 u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    ({req1, req0}),
      .update (arb_upd),
      .gnt    (arb_gnt),
      .vld    (arb_vld)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gid_q       <= P0;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         ram_wr      <= 1'b0;
         ram_rd      <= 1'b0;
         ram_add     <= '0;
         ram_data_in <= '0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         gid_q       <= gid_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         ram_wr      <= wr_d;
         ram_rd      <= rd_d;
         ram_add     <= add_d;
         ram_data_in <= din_d;
         ack0        <= ack0_d;
         ack1        <= ack1_d;
         rdata0      <= rdata0_d;
         rdata1      <= rdata1_d;
         busy        <= busy_d;
      end
   end

   // Outputs are registered, so ack and rdata are set on the transition into RESP.
   always_comb begin
      state_d  = state_q;
      gid_d    = gid_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      add_d    = ram_add;
      din_d    = ram_data_in;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0;
      rdata1_d = rdata1;
      arb_upd  = 1'b0;

      case (state_q)
         IDLE: begin
            if (arb_vld) begin
               arb_upd = 1'b1;
               gid_d   = arb_gnt;
               we_d    = (arb_gnt == P1) ? we1 : we0;
               add_d   = (arb_gnt == P1) ? addr1 : addr0;
               din_d   = (arb_gnt == P1) ? wdata1 : wdata0;
               wr_d    = we_d;
               rd_d    = ~we_d;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d = RESP;
               ack0_d  = (gid_q == P0);
               ack1_d  = (gid_q == P1);
            end else begin
               state_d = WAIT;
               cnt_d   = CNT_INIT;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = RESP;
               if (gid_q == P1) begin
                  ack1_d   = 1'b1;
                  rdata1_d = ram_data_out;
               end else begin
                  ack0_d   = 1'b1;
                  rdata0_d = ram_data_out;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural RAM, a shadow-memory reference and a round-robin fairness model.
module tb_ram_arbiter;

   localparam int LAT = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a [2];
   logic       we_a [2];
   logic [2:0] addr_a [2];
   logic [3:0] wdata_a [2];

   logic       ack0, ack1, busy, ram_wr, ram_rd;
   logic [3:0] rdata0, rdata1, ram_data_in, ram_data_out;
   logic [2:0] ram_add;

   int errors = 0;
   int checks = 0;
   logic [3:0] shadow [8];
   int ack_log [$];
   int others [2];
   int busy_cycles = 0;
   bit mon_off = 1'b1;
   logic [3:0] prev_r0, prev_r1;
   logic prev_wr = 1'b0, prev_rd = 1'b0;

   always #5 clk = ~clk;

   ram_arbiter #(.DW(4), .AW(3), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req_a[0]), .we0(we_a[0]), .addr0(addr_a[0]), .wdata0(wdata_a[0]),
      .ack0(ack0), .rdata0(rdata0),
      .req1(req_a[1]), .we1(we_a[1]), .addr1(addr_a[1]), .wdata1(wdata_a[1]),
      .ack1(ack1), .rdata1(rdata1),
      .busy(busy), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_add(ram_add),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // Single-port RAM with LAT-cycle read pipeline.
   logic [3:0] mem [8];
   logic [3:0] pipe [LAT];
   always @(posedge clk) begin
      if (ram_wr) mem[ram_add] <= ram_data_in;
      if (ram_rd) pipe[0] <= mem[ram_add];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_data_out = pipe[LAT-1];

   function automatic logic ack_of(input int p);
      return (p == 1) ? ack1 : ack0;
   endfunction

   function automatic logic [3:0] rdata_of(input int p);
      return (p == 1) ? rdata1 : rdata0;
   endfunction

   always @(negedge clk) begin
      if (!mon_off) begin
         checks++;
         if (ram_wr && ram_rd) begin errors++; $display("FAIL mon_wr_rd: wr=%0b rd=%0b, required not both", ram_wr, ram_rd); end
         checks++;
         if (ack0 && ack1) begin errors++; $display("FAIL mon_ack_overlap: ack0=%0b ack1=%0b, required not both", ack0, ack1); end
         checks++;
         if ((ram_wr && prev_wr) || (ram_rd && prev_rd)) begin errors++; $display("FAIL mon_pulse: ram strobe high 2 cycles, required 1"); end
         checks++;
         if (!ack0 && rdata0 !== prev_r0) begin errors++; $display("FAIL mon_rdata0_hold: got %h, required %h", rdata0, prev_r0); end
         checks++;
         if (!ack1 && rdata1 !== prev_r1) begin errors++; $display("FAIL mon_rdata1_hold: got %h, required %h", rdata1, prev_r1); end
      end
      if (ack0) ack_log.push_back(0);
      if (ack1) ack_log.push_back(1);
      if (busy === 1'b1) busy_cycles++;
      prev_r0 = rdata0;
      prev_r1 = rdata1;
      prev_wr = ram_wr;
      prev_rd = ram_rd;
   end

   task automatic do_txn(input int p, input logic w, input logic [2:0] a, input logic [3:0] d,
                         output int lat, output int wr_n, output int rd_n,
                         output logic [2:0] cap_a, output logic [3:0] cap_d, output int oth);
      @(negedge clk);
      we_a[p] = w; addr_a[p] = a; wdata_a[p] = d; req_a[p] = 1'b1;
      lat = 0; wr_n = 0; rd_n = 0; oth = 0; cap_a = '0; cap_d = '0;
      do begin
         @(negedge clk);
         lat++;
         if (ram_wr) begin wr_n++; cap_a = ram_add; cap_d = ram_data_in; end
         if (ram_rd) begin rd_n++; cap_a = ram_add; end
         if (ack_of(1 - p)) oth++;
      end while (!ack_of(p) && lat < 200);
      req_a[p] = 1'b0;
      if (ack_of(p) && w) shadow[a] = d;
   endtask

   task automatic cont_agent(input int p, input int n, input logic [3:0] d, output int bad);
      int t;
      bad = 0;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         we_a[p] = 1'b1; addr_a[p] = 3'(i); wdata_a[p] = d; req_a[p] = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!ack_of(p) && t < 200);
         if (!ack_of(p)) begin bad++; break; end
         shadow[3'(i)] = d;
      end
      req_a[p] = 1'b0;
   endtask

   task automatic rand_agent(input int p, input int n);
      int q = 1 - p;
      int t;
      logic w; logic [2:0] a; logic [3:0] d;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         w = 1'($urandom); a = 3'($urandom); d = 4'($urandom);
         we_a[p] = w; addr_a[p] = a; wdata_a[p] = d; others[p] = 0; req_a[p] = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!ack_of(p) && t < 200);
         req_a[p] = 1'b0;
         checks++;
         if (!ack_of(p)) begin
            errors++;
            $display("FAIL rand_timeout port %0d: no ack after %0d cycles, required ack", p, t);
            return;
         end
         if (w) shadow[a] = d;
         else begin
            checks++;
            if (rdata_of(p) !== shadow[a]) begin
               errors++;
               $display("FAIL rand_rdata port %0d addr %0d: got %h, required %h", p, a, rdata_of(p), shadow[a]);
            end
         end
         checks++;
         if (others[p] > 1) begin
            errors++;
            $display("FAIL rand_fairness port %0d: other port acked %0d times while waiting, required <=1", p, others[p]);
         end
         if (req_a[q]) others[q]++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ack0, ack1, busy, ram_wr, ram_rd, ram_add, ram_data_in, rdata0, rdata1} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", {ack0, ack1, busy, ram_wr, ram_rd, ram_add, ram_data_in, rdata0, rdata1});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ack0, ack1, busy, ram_wr, ram_rd} !== 5'h0) begin
         errors++;
         $display("FAIL reset_idle: got %b, required 00000", {ack0, ack1, busy, ram_wr, ram_rd});
      end
      mon_off = 1'b0;
   endtask

   task automatic test_write();
      int lat, wn, rn, oth; logic [2:0] ca; logic [3:0] cd;
      do_txn(0, 1'b1, 3'd3, 4'hA, lat, wn, rn, ca, cd, oth);
      checks++; if (lat !== 2) begin errors++; $display("FAIL write_lat: got %0d, required 2", lat); end
      checks++; if (wn !== 1 || rn !== 0) begin errors++; $display("FAIL write_strobes: wr=%0d rd=%0d, required 1/0", wn, rn); end
      checks++; if (ca !== 3'd3 || cd !== 4'hA) begin errors++; $display("FAIL write_bus: add=%0d din=%h, required 3/a", ca, cd); end
      checks++; if (oth !== 0) begin errors++; $display("FAIL write_ack1: got %0d pulses, required 0", oth); end
   endtask

   task automatic test_read();
      int lat, wn, rn, oth; logic [2:0] ca; logic [3:0] cd; logic [3:0] r0;
      r0 = rdata0;
      do_txn(1, 1'b0, 3'd3, 4'h0, lat, wn, rn, ca, cd, oth);
      checks++; if (lat !== 2 + LAT) begin errors++; $display("FAIL read_lat: got %0d, required %0d", lat, 2 + LAT); end
      checks++; if (rn !== 1 || wn !== 0 || ca !== 3'd3) begin errors++; $display("FAIL read_strobes: rd=%0d wr=%0d add=%0d, required 1/0/3", rn, wn, ca); end
      checks++; if (rdata1 !== 4'hA) begin errors++; $display("FAIL read_data: got %h, required a", rdata1); end
      checks++; if (rdata0 !== r0) begin errors++; $display("FAIL read_rdata0: got %h, required %h", rdata0, r0); end
      repeat (3) @(negedge clk);
      checks++; if (rdata1 !== 4'hA) begin errors++; $display("FAIL read_hold: got %h, required a", rdata1); end
   endtask

   task automatic test_contention();
      int b0, b1, bc0; logic [7:0] order;
      ack_log.delete();
      bc0 = busy_cycles;
      fork
         cont_agent(0, 4, 4'h1, b0);
         cont_agent(1, 4, 4'h2, b1);
      join
      #1;
      checks++; if (b0 + b1 != 0) begin errors++; $display("FAIL cont_timeout: got %0d timeouts, required 0", b0 + b1); end
      checks++; if (ack_log.size() != 8) begin errors++; $display("FAIL cont_count: got %0d acks, required 8", ack_log.size()); end
      order = '0;
      for (int i = 0; i < ack_log.size() && i < 8; i++) order[i] = (ack_log[i] == 1);
      checks++; if (order !== 8'hAA) begin errors++; $display("FAIL cont_order: got %b, required 10101010", order); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_last: got %b, required 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_drop: got %b, required 0", busy); end
      @(negedge clk);
      checks++; if (busy_cycles - bc0 != 16) begin errors++; $display("FAIL cont_busy_cycles: got %0d, required 16", busy_cycles - bc0); end
   endtask

   task automatic test_sweep();
      int lat, wn, rn, oth; logic [2:0] ca; logic [3:0] cd;
      logic [3:0] exp_s [8] = '{4'd5, 4'd4, 4'd7, 4'd6, 4'd1, 4'd0, 4'd3, 4'd2};
      for (int a = 0; a < 8; a++) begin
         do_txn(0, 1'b1, 3'(a), 4'(a ^ 5), lat, wn, rn, ca, cd, oth);
         checks++; if (lat !== 2 || ca !== 3'(a)) begin errors++; $display("FAIL sweep_wr addr %0d: lat=%0d add=%0d, required 2/%0d", a, lat, ca, a); end
      end
      for (int a = 0; a < 8; a++) begin
         do_txn(1, 1'b0, 3'(a), 4'h0, lat, wn, rn, ca, cd, oth);
         checks++; if (lat !== 2 + LAT) begin errors++; $display("FAIL sweep_rd_lat addr %0d: got %0d, required %0d", a, lat, 2 + LAT); end
         checks++; if (rdata1 !== exp_s[a]) begin errors++; $display("FAIL sweep_rdata addr %0d: got %h, required %h", a, rdata1, exp_s[a]); end
      end
   endtask

   task automatic test_late();
      int lat, wn, rn, oth, t, k; logic [2:0] ca; logic [3:0] cd;
      k = 0;
      fork
         do_txn(0, 1'b1, 3'd5, 4'hC, lat, wn, rn, ca, cd, oth);
         begin
            repeat (2) @(negedge clk);
            checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL late_access: ram_wr=%b, required 1", ram_wr); end
            we_a[1] = 1'b1; addr_a[1] = 3'd6; wdata_a[1] = 4'h9; req_a[1] = 1'b1;
            t = 0;
            while (!ack0 && t < 200) begin @(negedge clk); t++; end
            do begin @(negedge clk); k++; end while (!ack1 && k < 200);
            req_a[1] = 1'b0;
            if (ack1) shadow[6] = 4'h9;
         end
      join
      checks++; if (lat !== 2 || oth !== 0) begin errors++; $display("FAIL late_port0: lat=%0d ack1=%0d, required 2/0", lat, oth); end
      checks++; if (k !== 3) begin errors++; $display("FAIL late_port1: ack1 %0d cycles after ack0, required 3", k); end
   endtask

   task automatic test_reset_mid_read();
      int lat, wn, rn, oth, n_ack, b0, b1; logic [2:0] ca; logic [3:0] cd;
      do_txn(0, 1'b0, 3'd2, 4'h0, lat, wn, rn, ca, cd, oth);
      checks++; if (rdata0 !== shadow[2]) begin errors++; $display("FAIL rst_pre_read: got %h, required %h", rdata0, shadow[2]); end
      @(negedge clk);
      we_a[0] = 1'b0; addr_a[0] = 3'd3; req_a[0] = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({busy, ram_rd, ack0} !== 3'b100) begin errors++; $display("FAIL rst_in_wait: busy/rd/ack=%b, required 100", {busy, ram_rd, ack0}); end
      mon_off = 1'b1;
      rst = 1'b1;
      req_a[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({busy, ram_rd, ram_wr, ack0, ack1, rdata0, rdata1} !== 13'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %h, required 0", {busy, ram_rd, ram_wr, ack0, ack1, rdata0, rdata1});
      end
      n_ack = 0;
      @(negedge clk);
      mon_off = 1'b0;
      repeat (7) begin @(negedge clk); if (ack0 || ack1) n_ack++; end
      checks++; if (n_ack !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d acks, required 0", n_ack); end
      ack_log.delete();
      fork
         cont_agent(0, 1, 4'h3, b0);
         cont_agent(1, 1, 4'h4, b1);
      join
      #1;
      checks++;
      if (b0 + b1 != 0 || ack_log.size() != 2 || ack_log[0] != 0) begin
         errors++;
         $display("FAIL rst_priority: timeouts=%0d acks=%0d first=%0d, required 0/2/0", b0 + b1, ack_log.size(), (ack_log.size() > 0) ? ack_log[0] : -1);
      end
   endtask

   task automatic test_random();
      others[0] = 0; others[1] = 0;
      fork
         rand_agent(0, 30);
         rand_agent(1, 30);
      join
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle: busy=%b, required 0", busy); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
         req_a[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = '0; wdata_a[p] = '0;
      end
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_sweep();
      test_late();
      test_reset_mid_read();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
